// File: rtl/reg_bank_param.sv
// Parametrised 2R/1W register bank with optional hard-wired zero register, write-to-read
// bypass, and a sequential clear engine that zeroes one entry per cycle.
module reg_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              ready
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } bankState;

    bankState          state;
    bankState          stateNext;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cntNext;

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] mem [NREGS];

    logic              writeLegal;

    // A write to entry 0 is discarded when it is hard-wired to zero.
    assign writeLegal = we && !(ZERO_REG && (waddr == '0));
    assign ready      = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        memWe     = 1'b0;
        memAddr   = waddr;
        memData   = wdata;
        case (state)
            CLEAR: begin
                memWe   = 1'b1;
                memAddr = cnt;
                memData = '0;
                if (cnt == LAST_ADDR) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                memWe = writeLegal;
                if (clr_req) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = CLEAR;
                cntNext   = '0;
            end
        endcase
    end

    // NOTE: the array itself has no reset; the clear engine zeroes it and ready masks reads until then.
    always_ff @(posedge clk) begin
        if (rst && memWe) begin
            mem[memAddr] <= memData;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(
        input logic              isReady,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wrLegal,
        input logic [ADDR_W-1:0] wrAddr,
        input logic [DATA_W-1:0] wrData
    );
        if (!isReady) begin
            return '0;
        end else if (ZERO_REG && (addr == '0)) begin
            return '0;
        end else if (BYPASS && wrLegal && (wrAddr == addr)) begin
            return wrData;
        end else begin
            return stored;
        end
    endfunction

    assign rdata1 = readPort(ready, raddr1, mem[raddr1], writeLegal, waddr, wdata);
    assign rdata2 = readPort(ready, raddr2, mem[raddr2], writeLegal, waddr, wdata);

endmodule
